sreg_writer: RTL

- Programming engine for the writable special register file: the write-side counterpart of the synchronous sreg read port.
- Accepts burst-write and clear commands over a valid/ready command channel, then data beats over a valid/ready data channel.
- Drives a registered single write port (we/waddr/wdata) into a dual-port sreg RAM. The existing read port stays on the other side of that RAM, unchanged.

---
 rtl/sreg_pkg.sv | 14 +
 rtl/sreg_writer_if.sv | 33 +++
 rtl/sreg_wr_port.sv | 37 +++
 rtl/sreg_writer.sv | 109 ++++++++++
 4 files changed

// File: rtl/sreg_pkg.sv
// Shared definitions for the sreg register file: default geometry and the
// write-engine state encoding.
package sreg_pkg;

  localparam int unsigned SREG_ADDR_W = 4;
  localparam int unsigned SREG_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } sreg_wr_state_t;

endpackage

// File: rtl/sreg_writer_if.sv
// Command, data and RAM write-port signals of the sreg programming engine.
interface sreg_writer_if
  import sreg_pkg::*;
#(
  parameter int unsigned addr_w = SREG_ADDR_W,
  parameter int unsigned data_w = SREG_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_clear;
  logic [addr_w-1:0] cmd_addr;
  logic [addr_w-1:0] cmd_len;
  logic              dat_valid;
  logic              dat_ready;
  logic [data_w-1:0] dat_in;
  logic              we;
  logic [addr_w-1:0] waddr;
  logic [data_w-1:0] wdata;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_clear, cmd_addr, cmd_len, dat_valid, dat_in,
    input  cmd_ready, dat_ready, we, waddr, wdata, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_clear, cmd_addr, cmd_len, dat_valid, dat_in,
    output cmd_ready, dat_ready, we, waddr, wdata, busy, done
  );

endinterface

// File: rtl/sreg_wr_port.sv
// Output register stage for the sreg RAM write port and the done pulse.
module sreg_wr_port
  import sreg_pkg::*;
#(
  parameter int unsigned addr_w = SREG_ADDR_W,
  parameter int unsigned data_w = SREG_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [data_w-1:0] wr_data,
  input  logic              wr_done,
  output logic              we,
  output logic [addr_w-1:0] waddr,
  output logic [data_w-1:0] wdata,
  output logic              done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done  <= 1'b0;
    end else begin
      we   <= wr_en;
      done <= wr_done;
      // Address/data only move on a real write; we qualifies them.
      if (wr_en) begin
        waddr <= wr_addr;
        wdata <= wr_data;
      end
    end
  end

endmodule

// File: rtl/sreg_writer.sv
// Burst-write / clear programming engine driving the sreg RAM write port.
module sreg_writer
  import sreg_pkg::*;
#(
  parameter int unsigned addr_w = SREG_ADDR_W,
  parameter int unsigned data_w = SREG_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  sreg_writer_if.slave bus
);

  sreg_wr_state_t    state, state_n;
  logic [addr_w-1:0] ptr, ptr_n;
  logic [addr_w-1:0] count, count_n;

  logic              wr_en;
  logic              wr_done;
  logic [addr_w-1:0] wr_addr;
  logic [data_w-1:0] wr_data;

  logic              we_q;
  logic              done_q;
  logic [addr_w-1:0] waddr_q;
  logic [data_w-1:0] wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    count_n = count;
    wr_en   = 1'b0;
    wr_done = 1'b0;
    wr_addr = ptr;
    wr_data = '0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_clear) begin
            ptr_n   = '0;
            state_n = CLEAR;
          end else begin
            ptr_n   = bus.cmd_addr;
            count_n = bus.cmd_len;
            state_n = BURST;
          end
        end
      end
      BURST: begin
        if (bus.dat_valid) begin
          wr_en   = 1'b1;
          wr_data = bus.dat_in;
          ptr_n   = ptr + 1'b1;
          if (count == '0) begin
            wr_done = 1'b1;
            state_n = IDLE;
          end else begin
            count_n = count - 1'b1;
          end
        end
      end
      CLEAR: begin
        wr_en = 1'b1;
        ptr_n = ptr + 1'b1;
        if (ptr == '1) begin
          wr_done = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  sreg_wr_port #(
    .addr_w(addr_w),
    .data_w(data_w)
  ) u_wr_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_done (wr_done),
    .we      (we_q),
    .waddr   (waddr_q),
    .wdata   (wdata_q),
    .done    (done_q)
  );

  assign bus.cmd_ready = (state == IDLE);
  assign bus.dat_ready = (state == BURST);
  assign bus.busy      = (state != IDLE);
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.done      = done_q;

endmodule
